// File: rtl/univ_shift_engine.sv
// Multi-cycle universal shift engine.
// Performs hold/load/clear immediately. Logical, arithmetic and rotate
// shifts run over several cycles, moving at most STEP bits per cycle,
// so no full barrel shifter is needed.
// Handshake: start_i is accepted only while ready_o is high, and done_o
// pulses for one cycle when the result is on q_o.
module univ_shift_engine #(
    parameter int N    = 8,
    parameter int AW   = $clog2(N),
    parameter int STEP = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_i,
    input  logic [2:0]    op_i,
    input  logic [AW-1:0] amt_i,
    input  logic [N-1:0]  d_i,
    input  logic          si_i,
    output logic          ready_o,
    output logic          done_o,
    output logic [N-1:0]  q_o,
    output logic          so_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SLL  = 3'b010;
    localparam logic [2:0] OP_SRL  = 3'b011;
    localparam logic [2:0] OP_SRA  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_ROR  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    localparam logic [AW-1:0] STEP_W = AW'(STEP);
    localparam logic [AW-1:0] ONE_W  = AW'(1);
    localparam logic [AW:0]   N_W    = (AW+1)'(N);
    localparam logic [N-1:0]  ONES   = '1;

    logic [1:0]    state_q,  state_d;
    logic [2:0]    op_q,     op_d;
    logic [AW-1:0] shiftCnt_q, shiftCnt_d;
    logic [N-1:0]  data_q,   data_d;
    logic          so_q,     so_d;

    logic [AW-1:0] stepAmt;
    logic [AW:0]   stepComp;
    logic [AW-1:0] stepLess1;
    logic [N-1:0]  sllRes;
    logic [N-1:0]  srlRes;
    logic [N-1:0]  sraRes;
    logic [N-1:0]  rolRes;
    logic [N-1:0]  rorRes;
    logic [N-1:0]  leftOut;
    logic [N-1:0]  rightOut;
    logic [N-1:0]  shiftRes;
    logic          shiftSo;
    logic          immediateOp;

    // One shift step of s=min(STEP,remaining) bits for the latched op, plus the last bit leaving q
    always_comb begin
        stepAmt   = (shiftCnt_q < STEP_W) ? shiftCnt_q : STEP_W;
        stepComp  = N_W - {1'b0, stepAmt};
        stepLess1 = stepAmt - ONE_W;

        sllRes = (data_q << stepAmt) | (si_i ? ~(ONES << stepAmt) : '0);
        srlRes = (data_q >> stepAmt) | (si_i ? ~(ONES >> stepAmt) : '0);
        sraRes = $unsigned($signed(data_q) >>> stepAmt);
        rolRes = (data_q << stepAmt) | (data_q >> stepComp);
        rorRes = (data_q >> stepAmt) | (data_q << stepComp);

        leftOut  = data_q >> stepComp;
        rightOut = data_q >> stepLess1;

        shiftRes = data_q;
        shiftSo  = so_q;
        case (op_q)
            OP_SLL: begin
                shiftRes = sllRes;
                shiftSo  = leftOut[0];
            end
            OP_SRL: begin
                shiftRes = srlRes;
                shiftSo  = rightOut[0];
            end
            OP_SRA: begin
                shiftRes = sraRes;
                shiftSo  = rightOut[0];
            end
            OP_ROL: begin
                shiftRes = rolRes;
                shiftSo  = leftOut[0];
            end
            OP_ROR: begin
                shiftRes = rorRes;
                shiftSo  = rightOut[0];
            end
            default: begin
                shiftRes = data_q;
                shiftSo  = so_q;
            end
        endcase
    end

    // Sequencer: accept in IDLE, finish immediate ops at once, otherwise count down shift steps
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        shiftCnt_d = shiftCnt_q;
        data_d     = data_q;
        so_d       = so_q;

        immediateOp = (op_i == OP_HOLD) || (op_i == OP_LOAD) ||
                      (op_i == OP_CLR)  || (amt_i == '0);

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    op_d = op_i;
                    if (immediateOp) begin
                        if (op_i == OP_LOAD) begin
                            data_d = d_i;
                        end else if (op_i == OP_CLR) begin
                            data_d = '0;
                            so_d   = 1'b0;
                        end
                        state_d = ST_DONE;
                    end else begin
                        shiftCnt_d = amt_i;
                        state_d    = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                data_d     = shiftRes;
                so_d       = shiftSo;
                shiftCnt_d = shiftCnt_q - stepAmt;
                if (shiftCnt_q == stepAmt) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation without a done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_HOLD;
            shiftCnt_q <= '0;
            data_q     <= '0;
            so_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            shiftCnt_q <= shiftCnt_d;
            data_q     <= data_d;
            so_q       <= so_d;
        end
    end

    assign ready_o = (state_q == ST_IDLE);
    assign done_o  = (state_q == ST_DONE);
    assign q_o     = data_q;
    assign so_o    = so_q;

endmodule

// File: tb/tb_univ_shift_engine.sv
// Bench for univ_shift_engine: two instances (STEP=1 and STEP=2) share
// the same stimulus. Each is checked every cycle against a behavioural
// model that computes whole-operation results with integer arithmetic
// and derives latency as ceil(amt/STEP).
module tb_univ_shift_engine;

    localparam int N  = 8;
    localparam int AW = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] op;
    logic [2:0] amt;
    logic [7:0] d;
    logic       si;

    logic       rdy [2];
    logic       dn  [2];
    logic       sov [2];
    logic [7:0] qv  [2];

    int checks   = 0;
    int failures = 0;
    bit cmpEn    = 1'b0;

    // Behavioural model state per instance: 0 idle, 1 shifting, 2 done
    int         mPhase  [2];
    int         mLeft   [2];
    logic [7:0] mQ      [2];
    logic [7:0] mPendQ  [2];
    logic       mSo     [2];
    logic       mPendSo [2];
    bit         mQValid [2];

    // Results captured by the directed-operation task
    int         dLat      [2];
    int         dDone     [2];
    logic [7:0] dQ        [2];
    logic       dSo       [2];
    logic       dRdyAfter [2];

    always #5 clk = ~clk;

    univ_shift_engine #(.N(N), .AW(AW), .STEP(1)) dutStep1 (
        .clk     (clk),
        .reset   (reset),
        .start_i (start),
        .op_i    (op),
        .amt_i   (amt),
        .d_i     (d),
        .si_i    (si),
        .ready_o (rdy[0]),
        .done_o  (dn[0]),
        .q_o     (qv[0]),
        .so_o    (sov[0])
    );

    univ_shift_engine #(.N(N), .AW(AW), .STEP(2)) dutStep2 (
        .clk     (clk),
        .reset   (reset),
        .start_i (start),
        .op_i    (op),
        .amt_i   (amt),
        .d_i     (d),
        .si_i    (si),
        .ready_o (rdy[1]),
        .done_o  (dn[1]),
        .q_o     (qv[1]),
        .so_o    (sov[1])
    );

    function automatic int stepOf(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    function automatic bit isImmediate(input logic [2:0] o, input logic [2:0] a);
        return (o == 3'd0) || (o == 3'd1) || (o == 3'd7) || (a == 3'd0);
    endfunction

    // Whole-operation result for an 8-bit register, computed in one go
    function automatic logic [7:0] modelQ(input logic [2:0] o, input logic [2:0] a,
                                          input logic [7:0] dd, input logic s,
                                          input logic [7:0] qq);
        int q;
        int n;
        int r;
        int sq;
        q = int'(qq);
        n = int'(a);
        r = q;
        case (o)
            3'd0: r = q;
            3'd1: r = int'(dd);
            3'd2: r = (q << n) | (s ? ((1 << n) - 1) : 0);
            3'd3: r = (q >> n) | (s ? (((1 << n) - 1) << (8 - n)) : 0);
            3'd4: begin
                sq = (q >= 128) ? (q - 256) : q;
                r  = sq >>> n;
            end
            3'd5: r = (q << n) | (q >> (8 - n));
            3'd6: r = (q >> n) | (q << (8 - n));
            default: r = 0;
        endcase
        return r[7:0];
    endfunction

    // Last bit to leave the register over the whole operation
    function automatic logic modelSo(input logic [2:0] o, input logic [2:0] a,
                                     input logic [7:0] qq, input logic so);
        int q;
        int n;
        q = int'(qq);
        n = int'(a);
        if (o == 3'd7) return 1'b0;
        if (o == 3'd0 || o == 3'd1 || n == 0) return so;
        if (o == 3'd2 || o == 3'd5) return ((q >> (8 - n)) & 1) != 0;
        return ((q >> (n - 1)) & 1) != 0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Behavioural model advance on each clock edge, async reset like the DUT
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                mPhase[k]  <= 0;
                mLeft[k]   <= 0;
                mQ[k]      <= 8'h00;
                mSo[k]     <= 1'b0;
                mPendQ[k]  <= 8'h00;
                mPendSo[k] <= 1'b0;
                mQValid[k] <= 1'b1;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                case (mPhase[k])
                    0: if (start) begin
                        if (isImmediate(op, amt)) begin
                            mQ[k]     <= modelQ(op, amt, d, si, mQ[k]);
                            mSo[k]    <= modelSo(op, amt, mQ[k], mSo[k]);
                            mPhase[k] <= 2;
                        end else begin
                            mPendQ[k]  <= modelQ(op, amt, d, si, mQ[k]);
                            mPendSo[k] <= modelSo(op, amt, mQ[k], mSo[k]);
                            mLeft[k]   <= (int'(amt) + stepOf(k) - 1) / stepOf(k);
                            mQValid[k] <= 1'b0;
                            mPhase[k]  <= 1;
                        end
                    end
                    1: begin
                        mLeft[k] <= mLeft[k] - 1;
                        if (mLeft[k] == 1) begin
                            mQ[k]      <= mPendQ[k];
                            mSo[k]     <= mPendSo[k];
                            mQValid[k] <= 1'b1;
                            mPhase[k]  <= 2;
                        end
                    end
                    default: mPhase[k] <= 0;
                endcase
            end
        end
    end

    // Cycle-by-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (cmpEn && !reset) begin
            for (int k = 0; k < 2; k++) begin
                checkOutput($sformatf("ready_step%0d", stepOf(k)), {31'd0, rdy[k]}, {31'd0, (mPhase[k] == 0)});
                checkOutput($sformatf("done_step%0d", stepOf(k)), {31'd0, dn[k]}, {31'd0, (mPhase[k] == 2)});
                if (mQValid[k]) begin
                    checkOutput($sformatf("q_step%0d", stepOf(k)), {24'd0, qv[k]}, {24'd0, mQ[k]});
                    checkOutput($sformatf("so_step%0d", stepOf(k)), {31'd0, sov[k]}, {31'd0, mSo[k]});
                end
            end
        end
    end

    // Issue one operation, optionally poke a clear at cycle injectAt, and record latency/results
    task automatic applyStimulus(input logic [2:0] o, input logic [2:0] a, input logic [7:0] dd,
                                 input logic s, input int injectAt);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        amt   = a;
        d     = dd;
        si    = s;
        for (int k = 0; k < 2; k++) begin
            dLat[k]      = 0;
            dDone[k]     = 0;
            dQ[k]        = 8'h00;
            dSo[k]       = 1'b0;
            dRdyAfter[k] = 1'b0;
        end
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (dn[k] === 1'b1) begin
                    dDone[k]++;
                    if (dLat[k] == 0) begin
                        dLat[k] = cyc;
                        dQ[k]   = qv[k];
                        dSo[k]  = sov[k];
                    end
                end
                if (dLat[k] != 0 && cyc == dLat[k] + 1) dRdyAfter[k] = rdy[k];
            end
            start = (cyc == injectAt);
            if (cyc == injectAt) begin
                op  = 3'b111;
                amt = 3'd4;
                d   = 8'hFF;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int doneSeen;
        reset = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        amt   = 3'd0;
        d     = 8'h00;
        si    = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        cmpEn = 1'b1;

        // Reset values
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checkOutput("reset_q", {24'd0, qv[k]}, 32'h00);
            checkOutput("reset_so", {31'd0, sov[k]}, 32'h0);
            checkOutput("reset_ready", {31'd0, rdy[k]}, 32'h1);
            checkOutput("reset_done", {31'd0, dn[k]}, 32'h0);
        end

        // Load 0xA5: done one cycle after start, ready the cycle after
        applyStimulus(3'b001, 3'd0, 8'hA5, 1'b0, 0);
        for (int k = 0; k < 2; k++) begin
            checkOutput("load_latency", dLat[k], 32'd1);
            checkOutput("load_q", {24'd0, dQ[k]}, 32'hA5);
            checkOutput("load_ready_after", {31'd0, dRdyAfter[k]}, 32'h1);
            checkOutput("load_done_count", dDone[k], 32'd1);
        end

        // SRA by 3 on 0x96
        applyStimulus(3'b001, 3'd0, 8'h96, 1'b0, 0);
        applyStimulus(3'b100, 3'd3, 8'h00, 1'b0, 0);
        checkOutput("sra_latency_step1", dLat[0], 32'd4);
        checkOutput("sra_latency_step2", dLat[1], 32'd3);
        for (int k = 0; k < 2; k++) begin
            checkOutput("sra_q", {24'd0, dQ[k]}, 32'hF2);
            checkOutput("sra_so", {31'd0, dSo[k]}, 32'h1);
        end
        checkOutput("model_sra_q", {24'd0, mQ[0]}, 32'hF2);
        checkOutput("model_sra_so", {31'd0, mSo[0]}, 32'h1);

        // Reset asserted in the middle of a shift
        @(negedge clk);
        start = 1'b1;
        op    = 3'b100;
        amt   = 3'd6;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            checkOutput("midreset_q", {24'd0, qv[k]}, 32'h00);
            checkOutput("midreset_so", {31'd0, sov[k]}, 32'h0);
            checkOutput("midreset_ready", {31'd0, rdy[k]}, 32'h1);
            checkOutput("midreset_done", {31'd0, dn[k]}, 32'h0);
        end
        @(posedge clk);
        #3 reset = 1'b0;
        doneSeen = 0;
        repeat (10) begin
            @(negedge clk);
            if (dn[0] === 1'b1 || dn[1] === 1'b1) doneSeen++;
        end
        checkOutput("midreset_no_done", doneSeen, 32'd0);

        // ROL by 5 on 0x81 with a clear request while busy
        applyStimulus(3'b001, 3'd0, 8'h81, 1'b0, 0);
        applyStimulus(3'b101, 3'd5, 8'h00, 1'b0, 1);
        checkOutput("rol_latency_step1", dLat[0], 32'd6);
        checkOutput("rol_latency_step2", dLat[1], 32'd4);
        for (int k = 0; k < 2; k++) begin
            checkOutput("rol_q", {24'd0, dQ[k]}, 32'h30);
            checkOutput("rol_so", {31'd0, dSo[k]}, 32'h0);
            checkOutput("rol_done_count", dDone[k], 32'd1);
        end
        checkOutput("model_rol_q", {24'd0, mQ[1]}, 32'h30);

        // SLL by 2 on 0x0F with si=1
        applyStimulus(3'b001, 3'd0, 8'h0F, 1'b0, 0);
        applyStimulus(3'b010, 3'd2, 8'h00, 1'b1, 0);
        checkOutput("sll_latency_step1", dLat[0], 32'd3);
        checkOutput("sll_latency_step2", dLat[1], 32'd2);
        for (int k = 0; k < 2; k++) begin
            checkOutput("sll_q", {24'd0, dQ[k]}, 32'h3F);
            checkOutput("sll_so", {31'd0, dSo[k]}, 32'h0);
        end
        checkOutput("model_sll_q", {24'd0, mQ[0]}, 32'h3F);

        // SRL by 0: immediate, register unchanged
        applyStimulus(3'b011, 3'd0, 8'h55, 1'b1, 0);
        for (int k = 0; k < 2; k++) begin
            checkOutput("srl0_latency", dLat[k], 32'd1);
            checkOutput("srl0_q", {24'd0, dQ[k]}, 32'h3F);
        end

        // Randomized traffic; si only changes while both engines are idle
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (mPhase[0] == 0 && mPhase[1] == 0) si = 1'($urandom_range(0, 1));
            start = ($urandom_range(0, 9) < 4);
            op    = 3'($urandom_range(0, 7));
            amt   = 3'($urandom_range(0, 7));
            d     = 8'($urandom_range(0, 255));
        end
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        cmpEn = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a hung simulation
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
